morse_symbol_assembler: RTL

Parametrised successor to the fixed 5-symbol, 3-bit-counter capture path. It sits between `Morse_Decoder` (dot/dash/letter-gap/word-gap pulses) and the display or character-lookup logic. It collects up to `MAX_LEN` symbols into a code word and closes the character on a letter or word gap. Each closed character, or a bare word space, is pushed into a `DEPTH`-entry FIFO that the consumer drains with a valid/ready handshake.

---
 rtl/morse_symbol_assembler_if.sv | 32 +++
 rtl/morse_symbol_assembler.sv | 96 +++++++++
 2 files changed

// File: rtl/morse_symbol_assembler_if.sv
// Symbol-pulse input and show-ahead FIFO output bundle of the Morse symbol assembler.
// The producer/consumer side uses master; the assembler uses slave.
interface morse_symbol_assembler_if #(
    parameter int MAX_LEN = 5,
    parameter int DEPTH   = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(DEPTH + 1);

    logic               dot;
    logic               dash;
    logic               lg;
    logic               wg;
    logic               out_ready;
    logic               out_valid;
    logic [MAX_LEN-1:0] out_code;
    logic [LW-1:0]      out_len;
    logic               out_space;
    logic               out_err;
    logic [CW-1:0]      level;
    logic               overflow;

    modport master (
        output dot, dash, lg, wg, out_ready,
        input  out_valid, out_code, out_len, out_space, out_err, level, overflow
    );

    modport slave (
        input  dot, dash, lg, wg, out_ready,
        output out_valid, out_code, out_len, out_space, out_err, level, overflow
    );
endinterface

// File: rtl/morse_symbol_assembler.sv
// Collects dot/dash pulses into code words, closes them on letter/word gaps and
// queues the results in a show-ahead FIFO drained with valid/ready.
module morse_symbol_assembler #(
    parameter int MAX_LEN = 5,
    parameter int DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    morse_symbol_assembler_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic               err;
        logic               space;
        logic [LW-1:0]      len;
        logic [MAX_LEN-1:0] code;
    } entry_t;

    logic [MAX_LEN-1:0] acc_code_q, acc_code_d, cap_code;
    logic [LW-1:0]      acc_len_q, acc_len_d, cap_len;
    logic               acc_err_q, acc_err_d, cap_err;
    logic               close, push;
    entry_t             push_entry;

    entry_t             mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      level_q;
    logic               ovf_q;
    logic               full, valid, pop, wr_en, drop;
    entry_t             head;

    // The closing entry sees a symbol arriving in the same cycle as the gap.
    always_comb begin
        cap_code = acc_code_q;
        cap_len  = acc_len_q;
        cap_err  = acc_err_q;
        if (bus.dot ^ bus.dash) begin
            if (acc_len_q < LW'(MAX_LEN)) begin
                for (int i = 0; i < MAX_LEN; i++)
                    if (acc_len_q == LW'(i)) cap_code[i] = bus.dash;
                cap_len = acc_len_q + 1'b1;
            end else begin
                cap_err = 1'b1;
            end
        end
        close      = bus.lg | bus.wg;
        push       = bus.wg | (bus.lg & (cap_len != '0));
        push_entry = '{err: cap_err, space: bus.wg, len: cap_len, code: cap_code};
        acc_code_d = close ? '0 : cap_code;
        acc_len_d  = close ? '0 : cap_len;
        acc_err_d  = close ? 1'b0 : cap_err;
    end

    assign full  = (level_q == CW'(DEPTH));
    assign valid = (level_q != '0);
    assign pop   = valid & bus.out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_code_q <= '0;
            acc_len_q  <= '0;
            acc_err_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            acc_code_q <= acc_code_d;
            acc_len_q  <= acc_len_d;
            acc_err_q  <= acc_err_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + CW'(wr_en) - CW'(pop);
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.out_valid = valid;
    assign bus.out_code  = valid ? head.code  : '0;
    assign bus.out_len   = valid ? head.len   : '0;
    assign bus.out_space = valid ? head.space : 1'b0;
    assign bus.out_err   = valid ? head.err   : 1'b0;
    assign bus.level     = level_q;
    assign bus.overflow  = ovf_q;
endmodule
